hub75_framebuf: RTL

HUB75_FRAMEBUF -- requirements
Module: hub75_framebuf

---
 rtl/hub75_pkg.sv | 23 ++
 rtl/hub75_fb_bank.sv | 24 ++
 rtl/hub75_framebuf.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared types, default panel geometry and the gamma curve for the HUB75 frame buffer.
package hub75_pkg;

    localparam int HPIXEL_C   = 64;
    localparam int VPIXEL_C   = 64;
    localparam int BPP_C      = 8;
    localparam int SEGMENTS_C = 2;

    typedef logic [2:0][BPP_C-1:0] pixel_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fb_state_e;

    // Square-law curve: out = in^2 / 2^BPP, a cheap stand-in for gamma 2.0.
    function automatic logic [BPP_C-1:0] gamma_lut(input logic [BPP_C-1:0] v);
        logic [2*BPP_C-1:0] sq;
        sq = v * v;
        return sq[2*BPP_C-1:BPP_C];
    endfunction

endpackage

// File: rtl/hub75_fb_bank.sv
// Simple dual-port RAM bank: one synchronous write port, one registered read port.
module hub75_fb_bank #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hub75_framebuf.sv
// Double-buffered, segment-banked frame store for a HUB75 panel driver.
// Optional build macro HUB75_FRAMEBUF_GAMMA_EN applies the package gamma curve on writes.
//
// state   | meaning
// ST_FILL | back buffer accepting pixels, o_wr_ready high
// ST_FULL | back buffer holds a complete frame, waiting for vsync to swap
module hub75_framebuf
    import hub75_pkg::*;
#(
    parameter int HPIXEL_P   = HPIXEL_C,
    parameter int VPIXEL_P   = VPIXEL_C,
    parameter int BPP_P      = BPP_C,
    parameter int SEGMENTS_P = SEGMENTS_C,
    localparam int FRAME     = HPIXEL_P * VPIXEL_P,
    localparam int DEPTH     = FRAME / SEGMENTS_P,
    localparam int ADDR_W    = $clog2(FRAME),
    localparam int DEPTH_W   = $clog2(DEPTH),
    localparam int PIX_W     = 3 * BPP_P
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_wr_valid,
    output logic                                   o_wr_ready,
    input  logic [2:0][BPP_P-1:0]                  i_wr_data,
    input  logic                                   i_wr_last,
    input  logic                                   i_vsync,
    input  logic [ADDR_W-1:0]                      i_rd_addr,
    output logic [SEGMENTS_P-1:0][2:0][BPP_P-1:0]  o_rd_data,
    output logic                                   o_frame_valid,
    output logic                                   o_frame_err
);

    fb_state_e            state;
    logic [ADDR_W-1:0]    pix_cnt;
    logic                 front_sel;
    logic                 rd_sel;
    logic                 rd_valid;
    logic                 wr_fire;
    logic                 at_end;
    logic [ADDR_W-1:0]    wr_bank;
    logic [DEPTH_W-1:0]   wr_off;
    logic [2:0][BPP_P-1:0] wr_pix;
    logic [PIX_W-1:0]     bank_q [2][SEGMENTS_P];
    logic                 unused_rd_hi;

    assign wr_fire      = i_wr_valid & o_wr_ready;
    assign at_end       = (pix_cnt == ADDR_W'(FRAME - 1));
    assign wr_bank      = pix_cnt >> DEPTH_W;
    assign wr_off       = pix_cnt[DEPTH_W-1:0];
    assign unused_rd_hi = ^i_rd_addr[ADDR_W-1:DEPTH_W];

    always_comb begin
        wr_pix = i_wr_data;
`ifdef HUB75_FRAMEBUF_GAMMA_EN
        for (int c = 0; c < 3; c++) begin
            wr_pix[c] = BPP_P'(gamma_lut(BPP_C'(i_wr_data[c])));
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FILL;
            pix_cnt       <= '0;
            front_sel     <= 1'b0;
            o_wr_ready    <= 1'b1;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (wr_fire) begin
                        if (i_wr_last || at_end) begin
                            state       <= ST_FULL;
                            pix_cnt     <= '0;
                            o_wr_ready  <= 1'b0;
                            o_frame_err <= i_wr_last ^ at_end;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (i_vsync) begin
                        state         <= ST_FILL;
                        front_sel     <= ~front_sel;
                        o_frame_valid <= 1'b1;
                        o_wr_ready    <= 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    // Buffer select and valid travel with the read so a swap lines up with the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_sel   <= front_sel;
            rd_valid <= o_frame_valid;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar s = 0; s < SEGMENTS_P; s++) begin : g_seg
            hub75_fb_bank #(
                .DEPTH (DEPTH),
                .WIDTH (PIX_W)
            ) u_bank (
                .clk   (clk),
                .we    (wr_fire && (front_sel != 1'(b)) && (wr_bank == ADDR_W'(s))),
                .waddr (wr_off),
                .wdata (wr_pix),
                .raddr (i_rd_addr[DEPTH_W-1:0]),
                .rdata (bank_q[b][s])
            );
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int s = 0; s < SEGMENTS_P; s++) begin
            if (rd_valid) begin
                o_rd_data[s] = bank_q[rd_sel][s];
            end
        end
    end

endmodule
